// File: rtl/frame_fetch_pkg.sv
// Shared types, sizes and address mapping for the frame fetch unit.
// Imported by frame_fetch and fetch_skid_buf.
package frame_fetch_pkg;

    localparam int FRAMES    = 16;
    localparam int FRAME_DIM = 32;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 14;
    localparam int CNT_W     = 10;
    localparam int FRAME_W   = $clog2(FRAMES);
    localparam int POS_W     = $clog2(FRAME_DIM);
    localparam int BUF_W     = PIX_W + CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        PARAM,
        FETCH,
        DRAIN
    } state_t;

    // rcnt = {mb[1:0], blk[3:0], pos[3:0]} -> {frame, row, col}
    function automatic logic [ADDR_W-1:0] map_addr(
        input logic [CNT_W-1:0]   rcnt,
        input logic [FRAME_W-1:0] frame
    );
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
        row = {rcnt[9], rcnt[7:6], rcnt[3:2]};
        col = {rcnt[8], rcnt[5:4], rcnt[1:0]};
        return {frame, row, col};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry valid/ready buffer behind the 1-cycle SRAM read.
// space says a read issued now will find a free slot when it lands.
module fetch_skid_buf
    import frame_fetch_pkg::*;
#(
    parameter int W = BUF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         space
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic [1:0]   count;
    logic         pop;
    logic [2:0]   occ;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rp];
    assign pop       = out_valid & out_ready;
    assign occ       = {1'b0, count} + {2'b0, push} - {2'b0, pop};
    assign space     = (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= occ[1:0];
        end
    end

endmodule

// File: rtl/frame_fetch.sv
// Stores the pixel stream into SRAM and replays one frame to the core
// in macroblock / 4x4-block order.
module frame_fetch
    import frame_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_data,
    input  logic [PIX_W-1:0]  data,
    input  logic              in_valid_param,
    input  logic [3:0]        index,
    input  logic              mode,
    input  logic [4:0]        QP,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [PIX_W-1:0]  sram_wdata,
    input  logic [PIX_W-1:0]  sram_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic              mb_mode,
    output logic [4:0]        qp_out,
    output logic              pix_last,
    output logic              busy
);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   wcnt;
    logic [3:0]          modes;
    logic [3:0]          modes_nx;
    logic [4:0]          qp;
    logic [4:0]          qp_nx;
    logic [FRAME_W-1:0]  frame;
    logic [FRAME_W-1:0]  frame_nx;
    logic [2:0]          pcnt;
    logic [2:0]          pcnt_nx;
    logic [CNT_W-1:0]    rcnt;
    logic [CNT_W-1:0]    rcnt_nx;
    logic                rd_pend;
    logic [CNT_W-1:0]    rd_cnt;
    logic                issue;
    logic                space;
    logic                buf_valid;
    logic [BUF_W-1:0]    buf_data;
    logic [PIX_W-1:0]    b_pix;
    logic [CNT_W-1:0]    b_cnt;
    logic                b_last;
    logic                pop;

    assign issue = (state == FETCH) & ~in_valid_data & space;
    assign pop   = buf_valid & pix_ready;
    assign {b_pix, b_cnt, b_last} = buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (in_valid_data) begin
            wcnt <= wcnt + ADDR_W'(1);
        end else begin
            wcnt <= '0;
        end
    end

    // The single SRAM port: writes win, reads only in their gaps.
    always_comb begin
        sram_we    = in_valid_data & ~rst;
        sram_wdata = sram_we ? data : '0;
        sram_addr  = '0;
        if (!rst) begin
            if (in_valid_data) begin
                sram_addr = wcnt;
            end else if (issue) begin
                sram_addr = map_addr(rcnt, frame);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            modes   <= '0;
            qp      <= '0;
            frame   <= '0;
            pcnt    <= '0;
            rcnt    <= '0;
            rd_pend <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_nx;
            modes   <= modes_nx;
            qp      <= qp_nx;
            frame   <= frame_nx;
            pcnt    <= pcnt_nx;
            rcnt    <= rcnt_nx;
            rd_pend <= issue;
            rd_cnt  <= rcnt;
        end
    end

    always_comb begin
        state_nx = state;
        modes_nx = modes;
        qp_nx    = qp;
        frame_nx = frame;
        pcnt_nx  = pcnt;
        rcnt_nx  = rcnt;
        unique case (state)
            IDLE: begin
                if (in_valid_param) begin
                    state_nx = PARAM;
                    frame_nx = index;
                    qp_nx    = QP;
                    modes_nx = {3'b000, mode};
                    pcnt_nx  = 3'd1;
                end
            end
            PARAM: begin
                if (in_valid_param) begin
                    if (pcnt != 3'd4) begin
                        modes_nx[pcnt[1:0]] = mode;
                        pcnt_nx = pcnt + 3'd1;
                    end
                end else begin
                    state_nx = FETCH;
                    rcnt_nx  = '0;
                end
            end
            FETCH: begin
                if (issue) begin
                    rcnt_nx = rcnt + CNT_W'(1);
                    if (rcnt == '1) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && b_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    fetch_skid_buf #(
        .W (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data ({sram_rdata, rd_cnt, rd_cnt == '1}),
        .out_valid (buf_valid),
        .out_ready (pix_ready),
        .out_data  (buf_data),
        .space     (space)
    );

    assign pix_valid = buf_valid;
    assign pix_data  = buf_valid ? b_pix : '0;
    assign pix_cnt   = buf_valid ? b_cnt : '0;
    assign pix_last  = buf_valid & b_last;
    assign mb_mode   = buf_valid & modes[b_cnt[9:8]];
    assign qp_out    = buf_valid ? qp : '0;
    assign busy      = (state != IDLE);

endmodule
